hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Producer side of the EX-stage forwarding interface. It generates FWMuxAControl and FWMuxBControl, which select between RF / FWFromMEM / FWFromWB / MEM_ReadData, together with the pipeline stall and bubble controls.
- Keeps its own shadow copy of the destination, RegWrite and MemRead state of the instructions in EX and MEM.
- Forwarding selects are registered, so they are valid in the cycle the ID instruction occupies EX.
- Sits beside the ID stage and consumes only decoded ID fields.

Parameters:
- REG_ADDR_W, 5, register-index width.
- BRANCH_IN_ID, 1, when 1, branch operands are resolved in ID and branch hazards raise Stall.
- CNT_W, 32, width of the stall performance counter.

Ports:
- Clock  in  1  pipeline clock.
- Reset  in  1  synchronous, active-high.
- Hold  in  1  global freeze (memory wait). Shadow state, outputs and counter hold their values.
- ID_Rs  in  REG_ADDR_W  rs index of the instruction in ID.
- ID_Rt  in  REG_ADDR_W  rt index of the instruction in ID.
- ID_UsesRs  in  1  the ID instruction reads rs.
- ID_UsesRt  in  1  the ID instruction reads rt.
- ID_RegDest  in  REG_ADDR_W  resolved destination of the ID instruction (after the RegDest mux; 31 for jal).
- ID_RegWrite  in  1  the ID instruction writes the register file.
- ID_MemRead  in  1  the ID instruction is a load.
- ID_Branch  in  1  the ID instruction is a branch compared in ID.
- FWMuxAControl  out  2  registered select for the EX operand-A mux.
- FWMuxBControl  out  2  registered select for the EX operand-B mux.
- Stall  out  1  combinational; holds PC and IF/ID.
- Flush_IDEX  out  1  combinational; loads a bubble into ID/EX.
- StallCount  out  CNT_W  number of cycles in which Stall was asserted.

Behaviour:
- Reset (synchronous, checked on the Clock edge):
  - EX and MEM shadow slots invalid (RegWrite=0, MemRead=0, Dest=0).
  - FWMuxA/BControl = 2'b00.
  - StallCount = 0.
  - Stall and Flush_IDEX evaluate to 0 while Reset=1.
  - Reset mid-stall aborts the stall; the next cycle starts clean.
- Select encoding, fixed: 0 = RF, 1 = EX/MEM ALU result (FWFromMEM), 2 = MEM/WB result (FWFromWB), 3 = load data in MEM (MEM_ReadData).
- Match(slot, r) = slot.RegWrite and slot.Dest == r and r != 0. Register 0 is never forwarded.
- Select for operand r, computed from the pre-advance slots at each advancing edge:
  - Match(EX, r) and EX.MemRead: 3.
  - Match(EX, r): 1.
  - Match(MEM, r): 2.
  - Otherwise: 0.
- The EX slot has priority over the MEM slot (youngest producer wins). A select is 0 when the corresponding ID_Uses bit is 0.
- Branch hazard (BRANCH_IN_ID=1, ID_Branch=1, operand used):
  - Match(EX, r) (ALU or load): stall.
  - Match(MEM, r) with MEM.MemRead: stall.
  - ALU producer in MEM: no stall; the ID comparator bypass is outside this block.
- No load-use stall for non-branch consumers; select 3 covers that case.
- Stall = branch hazard and not Hold and not Reset. Flush_IDEX = Stall.
- Advancing edge (not Hold, not Reset):
  - MEM <= EX.
  - EX <= ID fields, or a bubble (all zero) when Stall=1.
  - FW selects <= computed values, or 0 when Stall=1.
  - StallCount increments when Stall=1 and saturates at all-ones.
- Hold=1: nothing updates, including the counter. Hold takes precedence over Stall.
- A load followed by a dependent branch stalls 2 cycles. An ALU op followed by a dependent branch stalls 1 cycle.

Decomposition:
- Shared package pipeline_defs:
  - FW select constants FW_RF=0, FW_EXMEM=1, FW_MEMWB=2, FW_MEMRD=3.
  - REG_ADDR_W.
  - Struct hazard_slot_t {Dest, RegWrite, MemRead}.
- One natural sub-module: hazard_slot_reg, a shadow-slot register with synchronous reset, hold and bubble insert, instantiated twice (EX and MEM).
- Match and priority logic is a function in the package.

Test Plan:
- Reset check: after Reset, FW selects = 0, Stall = 0, StallCount = 0. Issue add $3 with ID_Rs=3: select A = 0, because the slots were cleared.
- EX forward: add $5,$1,$2, then sub $6,$5,$5 on the next cycle. After the sub advances, FWMuxAControl = 1 and FWMuxBControl = 1.
- Priority: add $5, or $5, then and $7,$5,$0. Select A = 1 (youngest producer), select B = 0 (register 0).
- MEM forward and load: lw $4; nop; add $8,$4,$1 gives select A = 2. lw $4 immediately followed by add $8,$4,$1 gives select A = 3 and Stall = 0.
- Branch stalls:
  - lw $9 then beq $9,$0: Stall = 1 for exactly 2 cycles, two bubbles, StallCount = 2.
  - add $9 then beq $9: 1 stall cycle.
- Hold and reset:
  - Hold=1 during a branch stall: Stall = 0, slots, selects and counter frozen. The stall resumes after Hold drops.
  - Reset asserted mid-stall: everything clears on that edge.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / hazard unit.
//   - FW_* : operand-mux select encoding driven towards the EX stage
//   - hazard_slot_t : shadow copy of a pipeline slot's register-write state
//   - slot_match / fw_select / branch_hazard : match and priority rules
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FW_RF    = 2'd0;  // register file value
  localparam logic [1:0] FW_EXMEM = 2'd1;  // ALU result held in EX/MEM
  localparam logic [1:0] FW_MEMWB = 2'd2;  // result held in MEM/WB
  localparam logic [1:0] FW_MEMRD = 2'd3;  // load data coming out of MEM

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t dest;
    logic      reg_write;
    logic      mem_read;
  } hazard_slot_t;

  localparam hazard_slot_t SLOT_EMPTY = '{dest: '0, reg_write: 1'b0, mem_read: 1'b0};

  // Register 0 is hardwired, so it never counts as produced.
  function automatic logic slot_match(hazard_slot_t slot, reg_addr_t r);
    return slot.reg_write && (slot.dest == r) && (r != '0);
  endfunction

  // The EX slot holds the younger producer and therefore wins over MEM.
  function automatic logic [1:0] fw_select(hazard_slot_t ex_slot,
                                           hazard_slot_t mem_slot,
                                           reg_addr_t    r,
                                           logic         uses);
    logic [1:0] sel;
    sel = FW_RF;
    if (uses) begin
      if (slot_match(ex_slot, r)) begin
        sel = ex_slot.mem_read ? FW_MEMRD : FW_EXMEM;
      end else if (slot_match(mem_slot, r)) begin
        sel = FW_MEMWB;
      end
    end
    return sel;
  endfunction

  // A branch compares in ID, so any producer still in EX is too late, and a
  // load in MEM has no data yet. An ALU result in MEM is bypassed into the ID
  // comparator outside this block.
  function automatic logic branch_hazard(hazard_slot_t ex_slot,
                                         hazard_slot_t mem_slot,
                                         reg_addr_t    r,
                                         logic         uses);
    return uses && (slot_match(ex_slot, r) ||
                    (slot_match(mem_slot, r) && mem_slot.mem_read));
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the ID stage and the hazard/forwarding unit.
//   master : ID-stage side, drives decoded fields and hold, receives controls
//   slave  : hazard unit side
//   hold                 freeze everything (memory wait)
//   id_rs/id_rt          source indices of the ID instruction
//   id_uses_rs/rt        the ID instruction actually reads that source
//   id_reg_dest          resolved destination (31 for jal)
//   id_reg_write         ID instruction writes the register file
//   id_mem_read          ID instruction is a load
//   id_branch            ID instruction is a branch compared in ID
//   fw_mux_a/b_control   registered EX operand mux selects
//   stall                holds PC and IF/ID
//   flush_idex           loads a bubble into ID/EX
//   stall_count          saturating count of stall cycles
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic                  hold;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic [REG_ADDR_W-1:0] id_reg_dest;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_branch;
  logic [1:0]            fw_mux_a_control;
  logic [1:0]            fw_mux_b_control;
  logic                  stall;
  logic                  flush_idex;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output hold, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_dest,
           id_reg_write, id_mem_read, id_branch,
    input  fw_mux_a_control, fw_mux_b_control, stall, flush_idex, stall_count
  );

  modport slave (
    input  hold, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_dest,
           id_reg_write, id_mem_read, id_branch,
    output fw_mux_a_control, fw_mux_b_control, stall, flush_idex, stall_count
  );

endinterface

// File: rtl/hazard_forward_unit_slot_reg.sv
// Shadow register for one pipeline slot (EX or MEM).
//   clk, rst : clock and synchronous active-high reset
//   hold     : keep the current contents
//   bubble   : load an empty slot instead of d
//   d, q     : next / current slot contents
module hazard_slot_reg
  import hazard_forward_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  hazard_slot_t d,
  output hazard_slot_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SLOT_EMPTY;
    end else if (!hold) begin
      q <= bubble ? SLOT_EMPTY : d;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding and branch-hazard unit, sitting beside ID.
// Tracks shadow copies of the EX and MEM slots, registers the operand mux
// selects so they line up with the ID instruction once it reaches EX, and
// raises stall/flush_idex for branches whose operands are not yet available.
//   clk, rst : clock and synchronous active-high reset
//   bus      : hazard_forward_unit_if slave modport (see interface header)
// Parameters:
//   REG_ADDR_W   register index width (must match the package width)
//   BRANCH_IN_ID 1 = branches compare in ID and can raise stall
//   CNT_W        width of the stall cycle counter
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int BRANCH_IN_ID = 1,
  parameter int CNT_W        = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_slot_t id_slot;
  hazard_slot_t ex_slot;
  hazard_slot_t mem_slot;

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic       br_hazard;
  logic       stall;
  logic [1:0] sel_a_next;
  logic [1:0] sel_b_next;
  logic [1:0] sel_a_q;
  logic [1:0] sel_b_q;
  logic [CNT_W-1:0] stall_cnt;

  assign rs = bus.id_rs;
  assign rt = bus.id_rt;

  always_comb begin
    id_slot           = SLOT_EMPTY;
    id_slot.dest      = bus.id_reg_dest;
    id_slot.reg_write = bus.id_reg_write;
    id_slot.mem_read  = bus.id_mem_read;
  end

  always_comb begin
    br_hazard = 1'b0;
    if (BRANCH_IN_ID != 0 && bus.id_branch) begin
      br_hazard = branch_hazard(ex_slot, mem_slot, rs, bus.id_uses_rs) ||
                  branch_hazard(ex_slot, mem_slot, rt, bus.id_uses_rt);
    end
  end

  // Hold wins over the hazard: a frozen pipeline must not count or flush.
  assign stall = br_hazard && !bus.hold && !rst;

  always_comb begin
    sel_a_next = fw_select(ex_slot, mem_slot, rs, bus.id_uses_rs);
    sel_b_next = fw_select(ex_slot, mem_slot, rt, bus.id_uses_rt);
  end

  hazard_slot_reg u_ex_slot (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold),
    .bubble (stall),
    .d      (id_slot),
    .q      (ex_slot)
  );

  hazard_slot_reg u_mem_slot (
    .clk    (clk),
    .rst    (rst),
    .hold   (bus.hold),
    .bubble (1'b0),
    .d      (ex_slot),
    .q      (mem_slot)
  );

  // A stalled ID instruction enters EX as a bubble, so its selects must be RF.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_a_q <= FW_RF;
      sel_b_q <= FW_RF;
    end else if (!bus.hold) begin
      sel_a_q <= stall ? FW_RF : sel_a_next;
      sel_b_q <= stall ? FW_RF : sel_b_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign bus.fw_mux_a_control = sel_a_q;
  assign bus.fw_mux_b_control = sel_b_q;
  assign bus.stall            = stall;
  assign bus.flush_idex       = stall;
  assign bus.stall_count      = stall_cnt;

endmodule
